// File: rtl/cordic_pkg.sv
// Shared constants, FSM encoding and arctangent table for the iterative CORDIC rotator.
// All fixed-point constants are Q.14 (1.0 = 16384).
package cordic_pkg;

    localparam int K_INV   = 9949;
    localparam int PI_HALF = 25736;
    localparam int PI      = 51472;
    localparam int ONE     = 1 << 14;

    localparam logic MODE_LIN  = 1'b0;
    localparam logic MODE_CIRC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ITER,
        ST_SCALE,
        ST_DONE
    } state_t;

    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        logic [15:0] v;
        case (idx)
            4'd0:    v = 16'd12868;
            4'd1:    v = 16'd7596;
            4'd2:    v = 16'd4014;
            4'd3:    v = 16'd2037;
            4'd4:    v = 16'd1023;
            4'd5:    v = 16'd512;
            4'd6:    v = 16'd256;
            4'd7:    v = 16'd128;
            4'd8:    v = 16'd64;
            4'd9:    v = 16'd32;
            4'd10:   v = 16'd16;
            4'd11:   v = 16'd8;
            4'd12:   v = 16'd4;
            4'd13:   v = 16'd2;
            4'd14:   v = 16'd1;
            default: v = 16'd1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// One combinational CORDIC micro-rotation, circular or linear, on W-bit signed values.
module cordic_rot_step
    import cordic_pkg::*;
#(
    parameter int W = 20
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] z,
    input  logic [3:0]          i,
    input  logic                mode,
    output logic signed [W-1:0] x_nxt,
    output logic signed [W-1:0] y_nxt,
    output logic signed [W-1:0] z_nxt
);

    localparam logic signed [W-1:0] ONE_W = W'(ONE);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic signed [W-1:0] ang;
    logic                d_pos;

    always_comb begin
        // z == 0 steers positive, so the residual dithers around zero.
        d_pos = ~z[W-1];
        x_sh  = x >>> i;
        y_sh  = y >>> i;
        if (mode == MODE_CIRC) begin
            ang   = W'(atan_lut(i));
            x_nxt = d_pos ? (x - y_sh) : (x + y_sh);
        end else begin
            ang   = ONE_W >>> i;
            x_nxt = x;
        end
        y_nxt = d_pos ? (y + x_sh) : (y - x_sh);
        z_nxt = d_pos ? (z - ang) : (z + ang);
    end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator: circular rotation of (x,y) by z, or linear MAC y + x*z.
// One micro-rotation per cycle; valid/ready input, single-cycle result strobe.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int I_WIDE = 18,
    parameter int I_INT  = 4,
    parameter int ITER   = 13,
    parameter int GUARD  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_mode,
    input  logic [I_WIDE-1:0] i_x,
    input  logic [I_WIDE-1:0] i_y,
    input  logic [I_WIDE-1:0] i_z,
    output logic              o_valid,
    output logic [I_WIDE-1:0] o_x,
    output logic [I_WIDE-1:0] o_y,
    output logic [I_WIDE-1:0] o_z,
    output logic              o_range_err
);

    localparam int F = I_WIDE - I_INT;
    localparam int W = I_WIDE + GUARD;

    localparam logic [3:0]               CNT_LAST  = 4'(ITER - 1);
    localparam logic signed [W-1:0]      PI_W      = W'(PI);
    localparam logic signed [W-1:0]      PI_HALF_W = W'(PI_HALF);
    localparam logic signed [W-1:0]      TWO_W     = W'(2 * ONE);
    localparam logic signed [I_WIDE-1:0] KINV_Q    = I_WIDE'(K_INV);
    localparam logic signed [W-1:0]      SAT_MAX   = W'((2 ** (I_WIDE - 1)) - 1);
    localparam logic signed [W-1:0]      SAT_MIN   = -SAT_MAX - W'(1);

    function automatic logic signed [I_WIDE-1:0] sat_out(input logic signed [W-1:0] v);
        logic signed [W-1:0] c;
        if (v > SAT_MAX)      c = SAT_MAX;
        else if (v < SAT_MIN) c = SAT_MIN;
        else                  c = v;
        return I_WIDE'(c);
    endfunction

    // Gain compensation: floor of v * K_INV in Q.F.
    function automatic logic signed [W-1:0] scale_kinv(input logic signed [W-1:0] v);
        logic signed [W+I_WIDE-1:0] prod;
        prod = (W + I_WIDE)'(v) * (W + I_WIDE)'(KINV_Q);
        return W'(prod >>> F);
    endfunction

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                accept;
    logic                mode_r;
    logic                err_r;
    logic signed [W-1:0] x_r, y_r, z_r;
    logic signed [W-1:0] x_st, y_st, z_st;
    logic signed [W-1:0] x_pre, y_pre, z_pre;
    logic signed [W-1:0] z_abs;
    logic                pre_err;

    assign o_ready = (state == ST_IDLE);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_ITER && cnt != CNT_LAST) ? cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_PRE;
            ST_PRE:   state_nxt = ST_ITER;
            ST_ITER:  if (cnt == CNT_LAST) state_nxt = ST_SCALE;
            ST_SCALE: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // PRE stage: range check and quarter-turn pre-rotation for |z| > PI/2.
    always_comb begin
        z_abs   = z_r[W-1] ? -z_r : z_r;
        pre_err = (mode_r == MODE_CIRC) ? (z_abs > PI_W) : (z_abs >= TWO_W);
        x_pre   = x_r;
        y_pre   = y_r;
        z_pre   = z_r;
        if (mode_r == MODE_CIRC && !pre_err && z_abs > PI_HALF_W) begin
            if (!z_r[W-1]) begin
                x_pre = -y_r;
                y_pre = x_r;
                z_pre = z_r - PI_HALF_W;
            end else begin
                x_pre = y_r;
                y_pre = -x_r;
                z_pre = z_r + PI_HALF_W;
            end
        end
    end

    // ITER stage: one micro-rotation per cycle, index taken from the counter.
    cordic_rot_step #(
        .W(W)
    ) u_step (
        .x    (x_r),
        .y    (y_r),
        .z    (z_r),
        .i    (cnt),
        .mode (mode_r),
        .x_nxt(x_st),
        .y_nxt(y_st),
        .z_nxt(z_st)
    );

    always_ff @(posedge i_clk) begin
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    mode_r <= i_mode;
                    err_r  <= 1'b0;
                    x_r    <= W'($signed(i_x));
                    y_r    <= W'($signed(i_y));
                    z_r    <= W'($signed(i_z));
                end
            end
            ST_PRE: begin
                err_r <= pre_err;
                x_r   <= x_pre;
                y_r   <= y_pre;
                z_r   <= z_pre;
            end
            ST_ITER: begin
                if (!err_r) begin
                    x_r <= x_st;
                    y_r <= y_st;
                    z_r <= z_st;
                end
            end
            default: ;
        endcase
    end

    // SCALE stage: gain correction and saturation straight into the held outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_range_err <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_z         <= '0;
        end else begin
            o_valid <= (state == ST_SCALE);
            if (state == ST_SCALE) begin
                o_range_err <= err_r;
                if (mode_r == MODE_CIRC && !err_r) begin
                    o_x <= sat_out(scale_kinv(x_r));
                    o_y <= sat_out(scale_kinv(y_r));
                end else begin
                    o_x <= sat_out(x_r);
                    o_y <= sat_out(y_r);
                end
                o_z <= I_WIDE'(z_r);
            end
        end
    end

endmodule
